// File: rtl/segre_mem_arbiter_if.sv
// Channel-side and memory-side bundle for the segregated-cache memory arbiter.
// The arbiter binds to the slave modport; the environment drives through master.
interface segre_mem_arbiter_if #(
  parameter int N_CH      = 2,
  parameter int BUF_DEPTH = 16,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 128
);
  localparam int ID_W  = $clog2(N_CH);
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  logic [N_CH-1:0]             ch_valid_i;
  logic [N_CH-1:0]             ch_rd_i;
  logic [N_CH-1:0]             ch_wr_i;
  logic [N_CH-1:0][ADDR_W-1:0] ch_addr_i;
  logic [N_CH-1:0][LINE_W-1:0] ch_line_i;
  logic [N_CH-1:0]             ch_ready_o;
  logic [N_CH-1:0]             ch_err_o;

  logic                        mem_valid_o;
  logic                        mem_ready_i;
  logic [ID_W-1:0]             mem_id_o;
  logic                        mem_rd_o;
  logic                        mem_wr_o;
  logic [ADDR_W-1:0]           mem_addr_o;
  logic [LINE_W-1:0]           mem_line_o;

  logic                        mem_rsp_valid_i;
  logic [ID_W-1:0]             mem_rsp_id_i;
  logic [LINE_W-1:0]           mem_rsp_line_i;
  logic [N_CH-1:0]             ch_rsp_valid_o;
  logic [LINE_W-1:0]           ch_rsp_line_o;

  logic [CNT_W-1:0]            count_o;
  logic                        full_o;
  logic                        empty_o;

  modport slave (
    input  ch_valid_i, ch_rd_i, ch_wr_i, ch_addr_i, ch_line_i,
    output ch_ready_o, ch_err_o,
    output mem_valid_o, mem_id_o, mem_rd_o, mem_wr_o, mem_addr_o, mem_line_o,
    input  mem_ready_i,
    input  mem_rsp_valid_i, mem_rsp_id_i, mem_rsp_line_i,
    output ch_rsp_valid_o, ch_rsp_line_o,
    output count_o, full_o, empty_o
  );

  modport master (
    output ch_valid_i, ch_rd_i, ch_wr_i, ch_addr_i, ch_line_i,
    input  ch_ready_o, ch_err_o,
    input  mem_valid_o, mem_id_o, mem_rd_o, mem_wr_o, mem_addr_o, mem_line_o,
    output mem_ready_i,
    output mem_rsp_valid_i, mem_rsp_id_i, mem_rsp_line_i,
    input  ch_rsp_valid_o, ch_rsp_line_o,
    input  count_o, full_o, empty_o
  );
endinterface

// File: rtl/segre_mem_arbiter.sv
// Round-robin arbiter of N_CH cache channels into one in-order request buffer
// towards memory, plus id-based routing of memory responses back to channels.
module segre_mem_arbiter #(
  parameter int N_CH      = 2,
  parameter int BUF_DEPTH = 16,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 128
) (
  input logic clk_i,
  input logic rsn_i,
  segre_mem_arbiter_if.slave bus
);
  localparam int ID_W  = $clog2(N_CH);
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int PTR_W = $clog2(BUF_DEPTH);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] line;
  } entry_t;

  entry_t           ent_q [BUF_DEPTH];
  entry_t           new_ent, head_ent;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  logic [ID_W-1:0]  last_q, gnt_id;
  logic [N_CH-1:0]  err_q, legal, grant;
  logic             push, pop, full, empty;

  assign legal = bus.ch_valid_i & (bus.ch_rd_i ^ bus.ch_wr_i);
  assign full  = count_q == CNT_W'(BUF_DEPTH);
  assign empty = count_q == '0;
  assign pop   = !empty && bus.mem_ready_i;

  // Walk from the farthest candidate to the nearest so the nearest legal one wins.
  always_comb begin : rr_pick
    int idx;
    grant  = '0;
    gnt_id = '0;
    idx    = 0;
    for (int k = N_CH; k >= 1; k--) begin
      idx = (int'(last_q) + k) % N_CH;
      if (legal[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        gnt_id     = ID_W'(idx);
      end
    end
  end

  assign push           = rsn_i && (!full || pop) && (|legal);
  assign bus.ch_ready_o = push ? grant : '0;

  always_comb begin
    new_ent      = '0;
    new_ent.id   = gnt_id;
    new_ent.rd   = bus.ch_rd_i[gnt_id];
    new_ent.wr   = bus.ch_wr_i[gnt_id];
    new_ent.addr = bus.ch_addr_i[gnt_id];
    new_ent.line = bus.ch_line_i[gnt_id];
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      last_q  <= ID_W'(N_CH - 1);
      err_q   <= '0;
    end else begin
      if (push) begin
        tail_q <= tail_q + PTR_W'(1);
        last_q <= gnt_id;
      end
      if (pop) head_q <= head_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
      err_q <= err_q | (bus.ch_valid_i & ~(bus.ch_rd_i ^ bus.ch_wr_i));
    end
  end

  // Payload storage carries no reset; only occupancy state defines validity.
  always_ff @(posedge clk_i) begin
    if (push) ent_q[tail_q] <= new_ent;
  end

  assign head_ent        = ent_q[head_q];
  assign bus.mem_valid_o = !empty;
  assign bus.mem_id_o    = head_ent.id;
  assign bus.mem_rd_o    = head_ent.rd;
  assign bus.mem_wr_o    = head_ent.wr;
  assign bus.mem_addr_o  = head_ent.addr;
  assign bus.mem_line_o  = head_ent.line;
  assign bus.count_o     = count_q;
  assign bus.full_o      = full;
  assign bus.empty_o     = empty;
  assign bus.ch_err_o    = err_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_rsp
    assign bus.ch_rsp_valid_o[i] = bus.mem_rsp_valid_i && (bus.mem_rsp_id_i == ID_W'(i));
  end
  assign bus.ch_rsp_line_o = bus.mem_rsp_line_i;
endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Scoreboard bench for segre_mem_arbiter: main 2x16 instance, a 4-deep wrap
// instance and a 3-channel instance for response routing.
module tb_segre_mem_arbiter;
  logic clk = 1'b0;
  logic rsn;
  always #5 clk = ~clk;

  segre_mem_arbiter_if #(.N_CH(2), .BUF_DEPTH(16), .ADDR_W(32), .LINE_W(128)) b0 ();
  segre_mem_arbiter_if #(.N_CH(2), .BUF_DEPTH(4),  .ADDR_W(32), .LINE_W(128)) b4 ();
  segre_mem_arbiter_if #(.N_CH(3), .BUF_DEPTH(16), .ADDR_W(32), .LINE_W(128)) b3 ();

  segre_mem_arbiter #(.N_CH(2), .BUF_DEPTH(16), .ADDR_W(32), .LINE_W(128)) u0 (.clk_i(clk), .rsn_i(rsn), .bus(b0));
  segre_mem_arbiter #(.N_CH(2), .BUF_DEPTH(4),  .ADDR_W(32), .LINE_W(128)) u4 (.clk_i(clk), .rsn_i(rsn), .bus(b4));
  segre_mem_arbiter #(.N_CH(3), .BUF_DEPTH(16), .ADDR_W(32), .LINE_W(128)) u3 (.clk_i(clk), .rsn_i(rsn), .bus(b3));

  typedef struct { int id; logic rd; logic [31:0] addr; } exp_t;

  int          n_chk = 0;
  int          n_bad = 0;
  exp_t        q[$];
  logic [31:0] q4[$];
  int          m_cnt, m_last, cyc;
  logic [1:0]  m_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_next(input logic [1:0] lg, input int last);
    for (int s = 1; s <= 2; s++) begin
      if (lg[(last + s) % 2]) return (last + s) % 2;
    end
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_cnt  = 0;
    m_last = 1;
    m_err  = 2'b00;
  endtask

  // One clock on the main instance: predict, check at negedge, update model at posedge.
  task automatic tick0();
    logic [1:0] lg;
    int         g;
    bit         pop_m;
    exp_t       e, n;
    cyc++;
    b0.ch_addr_i[0] = 32'(cyc * 4);
    b0.ch_addr_i[1] = 32'(cyc * 4 + 1);
    lg    = b0.ch_valid_i & (b0.ch_rd_i ^ b0.ch_wr_i);
    pop_m = (m_cnt > 0) && b0.mem_ready_i;
    g     = (m_cnt < 16 || pop_m) ? rr_next(lg, m_last) : -1;
    if (g >= 0) begin
      n.id   = g;
      n.rd   = b0.ch_rd_i[g];
      n.addr = b0.ch_addr_i[g];
    end
    @(negedge clk);
    chk("ready",  b0.ch_ready_o, (g < 0) ? 2'b00 : (2'b01 << g));
    chk("count",  b0.count_o, m_cnt);
    chk("full",   b0.full_o, m_cnt == 16);
    chk("empty",  b0.empty_o, m_cnt == 0);
    chk("mvalid", b0.mem_valid_o, m_cnt != 0);
    chk("err",    b0.ch_err_o, m_err);
    if (pop_m) begin
      if (q.size() == 0) chk("sb_empty", 1, 0);
      else begin
        e = q.pop_front();
        chk("mem_id",   b0.mem_id_o, e.id);
        chk("mem_addr", b0.mem_addr_o, e.addr);
        chk("mem_rd",   b0.mem_rd_o, e.rd);
      end
    end
    @(posedge clk);
    if (g >= 0) begin
      q.push_back(n);
      m_last = g;
    end
    if (g >= 0 && !pop_m)      m_cnt++;
    else if (g < 0 && pop_m)   m_cnt--;
    m_err = m_err | (b0.ch_valid_i & ~(b0.ch_rd_i ^ b0.ch_wr_i));
    #1;
  endtask

  task automatic drive0(input logic [1:0] v, input logic [1:0] rd, input logic [1:0] wr, input logic mr);
    b0.ch_valid_i  = v;
    b0.ch_rd_i     = rd;
    b0.ch_wr_i     = wr;
    b0.mem_ready_i = mr;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pushes, pops;
    rsn = 1'b0;
    cyc = 0;
    b0.ch_addr_i = '0; b0.ch_line_i = '0; b0.mem_rsp_valid_i = 0; b0.mem_rsp_id_i = '0; b0.mem_rsp_line_i = '0;
    b4.ch_valid_i = '0; b4.ch_rd_i = '0; b4.ch_wr_i = '0; b4.ch_addr_i = '0; b4.ch_line_i = '0;
    b4.mem_ready_i = 0; b4.mem_rsp_valid_i = 0; b4.mem_rsp_id_i = '0; b4.mem_rsp_line_i = '0;
    b3.ch_valid_i = '0; b3.ch_rd_i = '0; b3.ch_wr_i = '0; b3.ch_addr_i = '0; b3.ch_line_i = '0;
    b3.mem_ready_i = 0; b3.mem_rsp_valid_i = 0; b3.mem_rsp_id_i = '0; b3.mem_rsp_line_i = '0;
    drive0(2'b11, 2'b11, 2'b00, 1'b0);
    model_reset();

    #12;
    chk("rst_count", b0.count_o, 0);
    chk("rst_empty", b0.empty_o, 1);
    chk("rst_full",  b0.full_o, 0);
    chk("rst_mval",  b0.mem_valid_o, 0);
    chk("rst_ready", b0.ch_ready_o, 2'b00);
    chk("rst_err",   b0.ch_err_o, 2'b00);
    @(posedge clk); #1;
    rsn = 1'b1;

    // Both channels reading, memory stalled: alternate grants until full.
    repeat (20) tick0();
    chk("fill_count", b0.count_o, 16);
    chk("fill_full",  b0.full_o, 1);

    // Full buffer with pops: push and pop in the same cycle.
    drive0(2'b01, 2'b01, 2'b00, 1'b1);
    repeat (20) tick0();
    chk("steady_count", b0.count_o, 16);

    // Illegal rd+wr on ch1 while draining.
    drive0(2'b10, 2'b10, 2'b10, 1'b1);
    repeat (20) tick0();
    drive0(2'b11, 2'b11, 2'b10, 1'b1);
    repeat (10) tick0();
    chk("err_sticky", b0.ch_err_o, 2'b10);
    drive0(2'b00, 2'b00, 2'b00, 1'b1);
    repeat (3) tick0();

    // Build occupancy of 5, then reset asynchronously mid-cycle.
    drive0(2'b01, 2'b01, 2'b00, 1'b0);
    repeat (5) tick0();
    chk("pre_rst_count", b0.count_o, 5);
    #2 rsn = 1'b0;
    #1;
    chk("arst_count", b0.count_o, 0);
    chk("arst_mval",  b0.mem_valid_o, 0);
    chk("arst_empty", b0.empty_o, 1);
    chk("arst_err",   b0.ch_err_o, 2'b00);
    chk("arst_ready", b0.ch_ready_o, 2'b00);
    model_reset();
    @(posedge clk); #1;
    rsn = 1'b1;
    drive0(2'b11, 2'b11, 2'b00, 1'b0);
    #1;
    chk("post_rst_gnt", b0.ch_ready_o, 2'b01);
    repeat (4) tick0();

    // Response routing, combinational.
    b0.mem_rsp_line_i = {64'h0, 64'hdead_beef_0123_4567};
    b0.mem_rsp_valid_i = 1; b0.mem_rsp_id_i = 1'b1; #1;
    chk("rsp_id1",  b0.ch_rsp_valid_o, 2'b10);
    chk("rsp_line", b0.ch_rsp_line_o[63:0], 64'hdead_beef_0123_4567);
    b0.mem_rsp_id_i = 1'b0; #1;
    chk("rsp_id0",  b0.ch_rsp_valid_o, 2'b01);
    b0.mem_rsp_valid_i = 0; #1;
    chk("rsp_none", b0.ch_rsp_valid_o, 2'b00);
    b3.mem_rsp_valid_i = 1; b3.mem_rsp_id_i = 2'd3; #1;
    chk("rsp3_id3", b3.ch_rsp_valid_o, 3'b000);
    b3.mem_rsp_id_i = 2'd2; #1;
    chk("rsp3_id2", b3.ch_rsp_valid_o, 3'b100);

    // Four-deep buffer: seven pushes with continuous pops wrap both pointers.
    drive0(2'b00, 2'b00, 2'b00, 1'b1);
    @(posedge clk); #1;
    pushes = 0;
    pops   = 0;
    b4.mem_ready_i = 1;
    b4.ch_rd_i     = 2'b01;
    for (int c = 0; c < 12; c++) begin
      b4.ch_valid_i   = (pushes < 7) ? 2'b01 : 2'b00;
      b4.ch_addr_i[0] = 32'h100 + 32'(pushes);
      @(negedge clk);
      if (b4.mem_valid_o && b4.mem_ready_i) begin
        if (q4.size() == 0) chk("wrap_spurious", 1, 0);
        else chk("wrap_addr", b4.mem_addr_o, q4.pop_front());
        pops++;
      end
      if (pushes < 7) chk("wrap_ready", b4.ch_ready_o, 2'b01);
      @(posedge clk);
      if (pushes < 7) begin
        q4.push_back(32'h100 + 32'(pushes));
        pushes++;
      end
      #1;
    end
    chk("wrap_pops",  pops, 7);
    chk("wrap_count", b4.count_o, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/segre_mem_arbiter.md
SEGRE_MEM_ARBITER -- requirements
Module: segre_mem_arbiter

Interface
REQ-001 The block SHALL have parameter N_CH, default 2, meaning the number of requesting cache channels (min 2).
REQ-002 The block SHALL have parameter BUF_DEPTH, default 16, meaning request buffer entries (power of 2, min 2).
REQ-003 The block SHALL have parameter ADDR_W, default 32, meaning request address width.
REQ-004 The block SHALL have parameter LINE_W, default 128, meaning cache-line payload width.
REQ-005 The block SHALL derive ID_W = $clog2(N_CH) and CNT_W = $clog2(BUF_DEPTH)+1.
REQ-006 The block SHALL have port clk_i  input  1  clock, one clock domain, all state on its rising edge.
REQ-007 The block SHALL have port rsn_i  input  1  reset, asynchronous, active-low.
REQ-008 The block SHALL have port ch_valid_i  input  N_CH  per-channel request valid.
REQ-009 The block SHALL have port ch_rd_i / ch_wr_i  input  N_CH each  per-channel read / write flag.
REQ-010 The block SHALL have port ch_addr_i  input  N_CH x ADDR_W  per-channel address.
REQ-011 The block SHALL have port ch_line_i  input  N_CH x LINE_W  per-channel write line.
REQ-012 The block SHALL have port ch_ready_o  output  N_CH  one-hot grant; a request is accepted when valid and ready are both high.
REQ-013 The block SHALL have port ch_err_o  output  N_CH  sticky illegal-request flag per channel.
REQ-014 The block SHALL have port mem_valid_o / mem_ready_i  output / input  1 each  memory-side handshake.
REQ-015 The block SHALL have port mem_id_o, mem_rd_o, mem_wr_o, mem_addr_o, mem_line_o  output  ID_W, 1, 1, ADDR_W, LINE_W  buffer-head request fields.
REQ-016 The block SHALL have port mem_rsp_valid_i, mem_rsp_id_i, mem_rsp_line_i  input  1, ID_W, LINE_W  memory response.
REQ-017 The block SHALL have port ch_rsp_valid_o, ch_rsp_line_o  output  N_CH, LINE_W  routed response.
REQ-018 The block SHALL have port count_o, full_o, empty_o  output  CNT_W, 1, 1  buffer occupancy and status.

Function
REQ-019 A request SHALL be legal only when exactly one of ch_rd_i[i], ch_wr_i[i] is set; illegal requests SHALL never be granted and SHALL set ch_err_o[i] on the next edge.
REQ-020 Grant SHALL be round-robin: the search starts at (last_grant+1) mod N_CH and grants the first legal valid channel; at most one ch_ready_o bit SHALL be high per cycle.
REQ-021 ch_ready_o SHALL be combinational from the current inputs and state; grant SHALL be allowed only when !full_o, or when full_o and a pop occurs in the same cycle.
REQ-022 last_grant SHALL update only on an accepted request; cycles with no accepted request SHALL leave it unchanged.
REQ-023 Each accepted request SHALL be written as {id, rd, wr, addr, line} at the tail; the entry SHALL become visible at mem_* one cycle later (no bypass, even when empty).
REQ-024 mem_valid_o SHALL equal !empty_o, and mem_* SHALL show the head entry; the head SHALL pop when mem_valid_o and mem_ready_i are both high.
REQ-025 mem_* fields SHALL hold stable while mem_valid_o is high and mem_ready_i is low.
REQ-026 Push only SHALL increment count, pop only SHALL decrement it, and simultaneous push and pop SHALL leave count unchanged; head and tail pointers SHALL wrap modulo BUF_DEPTH.
REQ-027 full_o SHALL equal (count==BUF_DEPTH), and empty_o SHALL equal (count==0).
REQ-028 ch_rsp_valid_o[i] SHALL equal mem_rsp_valid_i && (mem_rsp_id_i==i), and ch_rsp_line_o SHALL equal mem_rsp_line_i, combinationally; an id >= N_CH SHALL assert no bit.
REQ-029 Write-then-read ordering SHALL be preserved: entries SHALL leave the buffer strictly in acceptance order.

Reset
REQ-030 While rsn_i is low, count, head, tail and ch_err_o SHALL be 0, last_grant SHALL be N_CH-1, and buffer contents are don't-care.
REQ-031 While rsn_i is low, empty_o SHALL be 1, and mem_valid_o, full_o and ch_ready_o SHALL be 0.
REQ-032 Reset asserted mid-transfer SHALL discard all buffered entries with no pop reported, and channel 0 SHALL have first priority after release.

Verification
REQ-033 The bench SHALL check this: after reset, ch_valid_i=2'b11, both reads, mem_ready_i=0 -> grants in order ch0, ch1, ch0, ...; count_o reaches 16; full_o=1 and ch_ready_o=0 from then on.
REQ-034 The bench SHALL check this: with the buffer full, mem_ready_i=1 and ch_valid_i=2'b01 -> pop and push occur in the same cycle; count_o stays 16; mem_id_o follows acceptance order.
REQ-035 The bench SHALL check this: ch1 with rd=1 and wr=1 -> ch1 never granted; ch_err_o=2'b10 the next cycle and stays set until reset.
REQ-036 The bench SHALL check this: BUF_DEPTH=4, 7 pushes with continuous pops -> pointers wrap; mem_addr_o sequence equals the push sequence.
REQ-037 The bench SHALL check this: mem_rsp_valid_i=1 and mem_rsp_id_i=1 -> ch_rsp_valid_o=2'b10 in the same cycle; with id=3 and N_CH=3 -> 3'b000.
REQ-038 The bench SHALL check this: rsn_i pulsed low with count_o=5 -> count_o=0 and mem_valid_o=0 immediately (asynchronous); the first grant after release goes to ch0.
